// File: rtl/instr_sequencer.sv
// ============================================================================
// Module      : instr_sequencer
// Description : PC sequencer with zero flag, CALL/RET return stack, fault trap
// Revision    : 1.0
// ============================================================================
`default_nettype none

module instr_sequencer #(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             s_inc,
    input  logic                             wez,
    input  logic                             alu_zero,
    input  logic [1:0]                       jmp_type,
    input  logic                             ret,
    input  logic [PC_W-1:0]                  jmp_addr,
    input  logic                             imem_ready,
    output logic [PC_W-1:0]                  pc,
    output logic                             fetch_req,
    output logic                             zero_flag,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             fault
);

    localparam int C_DW = $clog2(STACK_DEPTH+1);
    localparam int C_AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    logic [1:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_zero_flag;
    logic [C_DW-1:0] r_depth;
    logic            r_fault;
    logic [PC_W-1:0] r_stack [STACK_DEPTH];

    logic            w_retire;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_next;
    logic            w_push;
    logic            w_pop;
    logic            w_fault_ev;
    logic [C_DW-1:0] w_depth_m1;
    logic [C_AW-1:0] w_top_idx;
    logic [C_AW-1:0] w_push_idx;
    logic            w_empty;
    logic            w_full;

    assign w_retire   = (r_state == S_RUN) && imem_ready;
    assign w_pc_inc   = r_pc + PC_W'(1);
    assign w_depth_m1 = r_depth - C_DW'(1);
    assign w_top_idx  = w_depth_m1[C_AW-1:0];
    assign w_push_idx = r_depth[C_AW-1:0];
    assign w_empty    = (r_depth == '0);
    assign w_full     = (r_depth == C_DW'(STACK_DEPTH));

    // Conditional jumps test the flag as it stood before this edge.
    always_comb begin
        w_pc_next  = w_pc_inc;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_fault_ev = 1'b0;
        if (ret) begin
            if (w_empty) begin
                w_fault_ev = 1'b1;
            end else begin
                w_pop     = 1'b1;
                w_pc_next = r_stack[w_top_idx];
            end
        end else if (!s_inc) begin
            case (jmp_type)
                2'b00: w_pc_next = jmp_addr;
                2'b01: if (r_zero_flag)  w_pc_next = jmp_addr;
                2'b10: if (!r_zero_flag) w_pc_next = jmp_addr;
                default: begin
                    if (w_full) begin
                        w_fault_ev = 1'b1;
                    end else begin
                        w_push    = 1'b1;
                        w_pc_next = jmp_addr;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_zero_flag <= 1'b0;
            r_depth     <= '0;
            r_fault     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_RUN;
                S_RUN: begin
                    if (w_retire) begin
                        if (w_fault_ev) begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_pc <= w_pc_next;
                            if (wez)    r_zero_flag <= alu_zero;
                            if (w_push) r_depth     <= r_depth + C_DW'(1);
                            if (w_pop)  r_depth     <= w_depth_m1;
                        end
                    end
                end
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stack contents need no reset; occupancy is tracked by r_depth.
    always_ff @(posedge clk) begin
        if (!reset && w_retire && w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign pc        = r_pc;
    assign fetch_req = (r_state == S_RUN);
    assign zero_flag = r_zero_flag;
    assign depth     = r_depth;
    assign fault     = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Directed self-checking bench for instr_sequencer
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_sequencer;

    logic       clk;
    logic       reset;
    logic       s_inc;
    logic       wez;
    logic       alu_zero;
    logic [1:0] jmp_type;
    logic       ret;
    logic [9:0] jmp_addr;
    logic       imem_ready;
    logic [9:0] pc;
    logic       fetch_req;
    logic       zero_flag;
    logic [2:0] depth;
    logic       fault;

    int n_total = 0;
    int n_bad   = 0;

    instr_sequencer #(.PC_W(10), .STACK_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_inc      (s_inc),
        .wez        (wez),
        .alu_zero   (alu_zero),
        .jmp_type   (jmp_type),
        .ret        (ret),
        .jmp_addr   (jmp_addr),
        .imem_ready (imem_ready),
        .pc         (pc),
        .fetch_req  (fetch_req),
        .zero_flag  (zero_flag),
        .depth      (depth),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic si, input logic [1:0] jt, input logic [9:0] addr,
                          input logic r, input logic we, input logic az);
        s_inc    = si;
        jmp_type = jt;
        jmp_addr = addr;
        ret      = r;
        wez      = we;
        alu_zero = az;
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b0;
        set_op(1'b0, 2'b00, 10'h0, 1'b0, 1'b0, 1'b0);
        step(); step();
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_fetch", 32'(fetch_req), 32'h0);
        check("rst_zf", 32'(zero_flag), 32'h0);
        check("rst_depth", 32'(depth), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);

        // Release: one idle cycle, then run sequentially
        reset = 1'b0; imem_ready = 1'b1;
        set_op(1'b1, 2'b00, 10'h0, 1'b0, 1'b0, 1'b0);
        check("idle_fetch", 32'(fetch_req), 32'h0);
        step();
        check("run_fetch", 32'(fetch_req), 32'h1);
        check("run_pc0", 32'(pc), 32'h0);
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("seq_pc%0d", i), 32'(pc), 32'(i));
        end

        // Conditional jumps
        set_op(1'b1, 2'b00, 10'h0, 1'b0, 1'b1, 1'b1);
        step();
        check("wez_pc", 32'(pc), 32'h6);
        check("wez_zf", 32'(zero_flag), 32'h1);
        set_op(1'b0, 2'b01, 10'h040, 1'b0, 1'b0, 1'b0);
        step();
        check("jz_taken", 32'(pc), 32'h40);
        set_op(1'b0, 2'b10, 10'h080, 1'b0, 1'b0, 1'b0);
        step();
        check("jnz_not_taken", 32'(pc), 32'h41);
        set_op(1'b0, 2'b01, 10'h050, 1'b0, 1'b1, 1'b0);
        step();
        check("jz_old_flag", 32'(pc), 32'h50);
        check("jz_flag_cleared", 32'(zero_flag), 32'h0);
        set_op(1'b0, 2'b10, 10'h060, 1'b0, 1'b0, 1'b0);
        step();
        check("jnz_taken", 32'(pc), 32'h60);
        set_op(1'b0, 2'b01, 10'h070, 1'b0, 1'b0, 1'b0);
        step();
        check("jz_not_taken", 32'(pc), 32'h61);

        // Stall: nothing moves for three cycles
        imem_ready = 1'b0;
        set_op(1'b0, 2'b00, 10'h123, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_pc%0d", i), 32'(pc), 32'h61);
            check($sformatf("stall_zf%0d", i), 32'(zero_flag), 32'h0);
            check($sformatf("stall_depth%0d", i), 32'(depth), 32'h0);
        end
        imem_ready = 1'b1;
        step();
        check("stall_release_pc", 32'(pc), 32'h123);
        check("stall_release_zf", 32'(zero_flag), 32'h1);

        // CALL / RET
        set_op(1'b0, 2'b00, 10'h010, 1'b0, 1'b0, 1'b0);
        step();
        check("j_0x10", 32'(pc), 32'h10);
        set_op(1'b0, 2'b11, 10'h080, 1'b0, 1'b0, 1'b0);
        step();
        check("call_pc", 32'(pc), 32'h80);
        check("call_depth", 32'(depth), 32'h1);
        set_op(1'b1, 2'b00, 10'h0, 1'b1, 1'b0, 1'b0);
        step();
        check("ret_pc", 32'(pc), 32'h11);
        check("ret_depth", 32'(depth), 32'h0);
        set_op(1'b0, 2'b11, 10'h090, 1'b0, 1'b0, 1'b0);
        step();
        check("call2_pc", 32'(pc), 32'h90);
        set_op(1'b0, 2'b11, 10'h200, 1'b1, 1'b0, 1'b0);
        step();
        check("ret_wins_pc", 32'(pc), 32'h12);
        check("ret_wins_depth", 32'(depth), 32'h0);

        // Nested calls return in LIFO order
        set_op(1'b0, 2'b11, 10'h100, 1'b0, 1'b0, 1'b0);
        step();
        set_op(1'b0, 2'b11, 10'h200, 1'b0, 1'b0, 1'b0);
        step();
        check("nest_depth", 32'(depth), 32'h2);
        set_op(1'b1, 2'b00, 10'h0, 1'b1, 1'b0, 1'b0);
        step();
        check("nest_ret1", 32'(pc), 32'h101);
        step();
        check("nest_ret2", 32'(pc), 32'h13);

        // PC wrap and wrapped return address
        set_op(1'b0, 2'b00, 10'h3FF, 1'b0, 1'b0, 1'b0);
        step();
        set_op(1'b1, 2'b00, 10'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("wrap_pc", 32'(pc), 32'h0);
        set_op(1'b0, 2'b00, 10'h3FF, 1'b0, 1'b0, 1'b0);
        step();
        set_op(1'b0, 2'b11, 10'h020, 1'b0, 1'b0, 1'b0);
        step();
        check("wrap_call_pc", 32'(pc), 32'h20);
        set_op(1'b1, 2'b00, 10'h0, 1'b1, 1'b0, 1'b0);
        step();
        check("wrap_ret_pc", 32'(pc), 32'h0);
        check("wrap_ret_depth", 32'(depth), 32'h0);

        // Overflow on the fifth CALL
        for (int i = 0; i < 4; i++) begin
            set_op(1'b0, 2'b11, 10'(10'h100 + i), 1'b0, 1'b0, 1'b0);
            step();
        end
        check("full_depth", 32'(depth), 32'h4);
        check("full_pc", 32'(pc), 32'h103);
        set_op(1'b0, 2'b11, 10'h104, 1'b0, 1'b0, 1'b0);
        step();
        check("ovf_fault", 32'(fault), 32'h1);
        check("ovf_fetch", 32'(fetch_req), 32'h0);
        check("ovf_pc", 32'(pc), 32'h103);
        check("ovf_depth", 32'(depth), 32'h4);
        set_op(1'b1, 2'b00, 10'h0, 1'b0, 1'b1, 1'b0);
        step(); step();
        check("fault_frozen_pc", 32'(pc), 32'h103);
        check("fault_frozen_zf", 32'(zero_flag), 32'h1);
        check("fault_sticky", 32'(fault), 32'h1);

        // Reset out of fault
        reset = 1'b1;
        step();
        check("frst_pc", 32'(pc), 32'h0);
        check("frst_fault", 32'(fault), 32'h0);
        check("frst_depth", 32'(depth), 32'h0);
        check("frst_zf", 32'(zero_flag), 32'h0);
        check("frst_fetch", 32'(fetch_req), 32'h0);

        // Underflow
        reset = 1'b0;
        set_op(1'b1, 2'b00, 10'h0, 1'b1, 1'b0, 1'b0);
        step();
        check("udf_run", 32'(fetch_req), 32'h1);
        step();
        check("udf_fault", 32'(fault), 32'h1);
        check("udf_pc", 32'(pc), 32'h0);
        check("udf_fetch", 32'(fetch_req), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Front end of the single-cycle CPU. It holds the program counter and fetches each opcode from instruction memory. It consumes the decoded control signals (s_inc, wez) and the ALU zero result, and produces the next PC. It supports a zero-flag register for conditional jumps and a small hardware return stack for CALL/RET.

Parameters:
PC_W, 10, program counter / instruction address width
STACK_DEPTH, 4, return-stack entries (>=1)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
s_inc  in  1  1 = sequential (PC+1), 0 = jump cycle
wez  in  1  write-enable for zero flag register
alu_zero  in  1  ALU zero output of current instruction
jmp_type  in  2  opcode[1:0] on jump cycles: 00 J, 01 JZ, 10 JNZ, 11 CALL
ret  in  1  return request (pops stack); decoded externally
jmp_addr  in  PC_W  jump target from instruction immediate field
imem_ready  in  1  instruction memory has current opcode valid
pc  out  PC_W  current instruction address
fetch_req  out  1  sequencer requests instruction at pc
zero_flag  out  1  registered zero flag
depth  out  clog2(STACK_DEPTH+1)  current stack occupancy
fault  out  1  sticky stack overflow/underflow indicator

Behaviour:
- Reset (synchronous, active-high, overrides everything, including mid-operation): state=S_IDLE, pc=0, zero_flag=0, depth=0, fault=0, fetch_req=0. Stack contents are don't-care.
- States: S_IDLE, S_RUN, S_FAULT.
- S_IDLE: one cycle after reset deasserts, then S_RUN. pc holds 0 and fetch_req=0.
- S_RUN:
  - fetch_req=1 (combinational from state).
  - An instruction retires on an edge with imem_ready=1. With imem_ready=0, all registers hold and control inputs are ignored (stall).
- Retire priority (highest first):
  1. ret=1: if depth=0, go to S_FAULT, fault=1, pc unchanged. Else pc<=stack[depth-1], depth-1.
  2. s_inc=1: pc<=pc+1, modulo 2^PC_W (wraps from all-ones to 0).
  3. s_inc=0, jmp_type=00: pc<=jmp_addr.
  4. s_inc=0, jmp_type=01: pc<=jmp_addr if zero_flag=1, else pc+1.
  5. s_inc=0, jmp_type=10: pc<=jmp_addr if zero_flag=0, else pc+1.
  6. s_inc=0, jmp_type=11 (CALL): if depth=STACK_DEPTH, go to S_FAULT, fault=1, pc unchanged. Else stack[depth]<=pc+1 (wrapped), depth+1, pc<=jmp_addr.
- Zero flag:
  - On a retiring edge with wez=1, zero_flag<=alu_zero.
  - JZ/JNZ evaluate the pre-edge zero_flag, even when wez=1 on the same edge.
  - Flag updates only on retiring edges, never during a stall.
- S_FAULT: fetch_req=0 and fault=1. pc, depth and zero_flag frozen. Exit only via reset.
- Latency: new pc is visible the cycle after the retiring edge. No combinational path from inputs to pc.
- depth is never above STACK_DEPTH and never wraps.

Test Plan:
- Reset then run: reset high 2 cycles, release, imem_ready=1, s_inc=1 for 5 cycles -> pc=0 during S_IDLE, then 1,2,3,4,5; fetch_req rises exactly one cycle after release.
- Conditional jumps: wez=1, alu_zero=1 at pc=3; next cycle s_inc=0, jmp_type=01, jmp_addr=0x40 -> pc=0x40. Repeat with jmp_type=10 -> pc=pc+1. Same-edge wez=1, alu_zero=0 with JZ still takes the jump on the old flag=1.
- Stall: imem_ready=0 for 3 cycles while s_inc=0, jmp_type=00, wez=1, alu_zero=1 -> pc, zero_flag, depth unchanged. Retire on the 4th cycle -> pc=jmp_addr.
- CALL/RET: at pc=0x10, CALL 0x80 -> pc=0x80, depth=1. Then ret=1 -> pc=0x11, depth=0. ret asserted together with s_inc=0 CALL -> ret wins.
- Overflow/underflow: 4 CALLs then a 5th -> fault=1, fetch_req=0, pc stays at the 4th target. After reset, a ret with depth=0 -> fault=1. Reset asserted while in S_FAULT -> all outputs return to reset values.
- Wrap: pc=0x3FF with s_inc=1 -> pc=0x000. CALL at 0x3FF -> pushed return address is 0x000.
